// File: rtl/hm_rd_req_pkg.sv
// Shared types and TLP constants for the host-memory read requester.
package hm_rd_req_pkg;

  typedef enum logic [2:0] {
    RQ_IDLE, RQ_HDR0, RQ_HDR1, RQ_WAIT_CPL, RQ_CPL_DATA
  } rq_state_e;

  typedef enum logic [1:0] {RX_IDLE, RX_QW1, RX_DATA, RX_SKIP} rx_state_e;

  localparam logic [7:0] TLP_FMT_MRD32 = 8'h00;
  localparam logic [7:0] TLP_FMT_CPLD  = 8'h4A;

  localparam logic [2:0] CPL_SC  = 3'b000;
  localparam logic [2:0] CPL_UR  = 3'b001;
  localparam logic [2:0] CPL_CRS = 3'b010;
  localparam logic [2:0] CPL_CA  = 3'b100;

  // First header QW of a 3DW MRd: TC/TD/EP/attr all zero, fdw always F.
  function automatic logic [63:0] mrd_qw0(logic [9:0] len, logic [15:0] req_id, logic [7:0] tag);
    logic [3:0] ldw;
    ldw = (len == 10'd1) ? 4'h0 : 4'hF;
    return {TLP_FMT_MRD32, 8'h00, 6'h00, len, req_id, tag, ldw, 4'hF};
  endfunction

  function automatic logic [31:0] bswap32(logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/hm_rd_req_cpl_rx.sv
// CplD receive side: matches our completions and unpacks payload DWs per QW beat.
module hm_rd_req_cpl_rx import hm_rd_req_pkg::*; #(
  parameter logic [7:0] TAG = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic [15:0] req_id,
  input  logic [63:0] trn_rd,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rrem_n,
  input  logic        trn_rsrc_rdy_n,
  output logic [31:0] dw_hi,
  output logic [31:0] dw_lo,
  output logic        vld_hi,
  output logic        vld_lo,
  output logic        last,
  output logic        err
);

  rx_state_e st_q, st_d;
  logic      cpld_q, cpld_d, bad_q, bad_d;
  logic      beat, lo_ok, match;

  assign dw_hi = trn_rd[63:32];
  assign dw_lo = trn_rd[31:0];

  always_comb begin
    st_d   = st_q;
    cpld_d = cpld_q;
    bad_d  = bad_q;
    vld_hi = 1'b0;
    vld_lo = 1'b0;
    last   = 1'b0;
    err    = 1'b0;
    beat   = !trn_rsrc_rdy_n;
    // Lower DW of the final QW only carries data when rem says both halves are valid.
    lo_ok  = trn_reof_n || !trn_rrem_n;
    match  = cpld_q && active && (trn_rd[63:48] == req_id) && (trn_rd[47:40] == TAG);
    case (st_q)
      RX_IDLE: if (beat && !trn_rsof_n) begin
        cpld_d = (trn_rd[63:56] == TLP_FMT_CPLD);
        bad_d  = (trn_rd[15:13] != CPL_SC) || trn_rd[46];
        if (trn_reof_n) st_d = RX_QW1;
      end
      RX_QW1: if (beat) begin
        if (match && bad_q) err = 1'b1;
        else if (match) begin
          vld_lo = lo_ok;
          last   = !trn_reof_n;
        end
        if (!trn_reof_n)          st_d = RX_IDLE;
        else if (match && !bad_q) st_d = RX_DATA;
        else                      st_d = RX_SKIP;
      end
      RX_DATA: if (beat) begin
        vld_hi = 1'b1;
        vld_lo = lo_ok;
        last   = !trn_reof_n;
        if (!trn_reof_n) st_d = RX_IDLE;
      end
      default: if (beat && !trn_reof_n) st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= RX_IDLE;
      cpld_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cpld_q <= cpld_d;
      bad_q  <= bad_d;
    end
  end

endmodule

// File: rtl/hm_rd_req.sv
// Host-memory read requester: one MRd out, CplD payload into local RAM.
// Define HM_RD_REQ_TIMEOUT_EN to abort with req_err when completions stop arriving.
module hm_rd_req import hm_rd_req_pkg::*; #(
  parameter int          MEM_AW      = 10,
  parameter logic [9:0]  MAX_LEN     = 10'd128,
  parameter logic [7:0]  TAG         = 8'h01,
  parameter logic [19:0] TIMEOUT_CYC = 20'hFFFFF
) (
  input  logic              trn_clk,
  input  logic              sys_rst,
  input  logic              trn_lnk_up_n,
  input  logic              req_start,
  input  logic [31:0]       req_addr,
  input  logic [9:0]        req_len,
  output logic              req_busy,
  output logic              req_done,
  output logic              req_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_we,
  output logic [63:0]       trn_td,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_trem_n,
  output logic              trn_tsrc_rdy_n,
  output logic              trn_cyc_n,
  input  logic              trn_tdst_rdy_n,
  input  logic [63:0]       trn_rd,
  input  logic              trn_rsof_n,
  input  logic              trn_reof_n,
  input  logic              trn_rrem_n,
  input  logic              trn_rsrc_rdy_n,
  input  logic [7:0]        cfg_bus_number,
  input  logic [4:0]        cfg_device_number,
  input  logic [2:0]        cfg_function_number,
  output logic [15:0]       stat_rd_cnt
);

  // Full data QWs bring two DWs against one RAM write per cycle; backlog stays under len/2.
  localparam int FQ_AW = $clog2(int'(MAX_LEN)) - 1;
  localparam int FQ_CW = FQ_AW + 1;

  logic        rst, active, start_bad, timeout, acc_hi, acc_lo, fq_empty, pop_fq, wr_en;
  logic        push0, push1;
  logic [31:0] push0_dw, push1_dw, wdw;
  logic [15:0] req_id;
  logic [31:0] rx_hi, rx_lo;
  logic        rx_vhi, rx_vlo, rx_last, rx_err;
  logic        unused_addr;

  rq_state_e         st_q, st_d;
  logic [31:2]       addr_q, addr_d;
  logic [9:0]        len_q, len_d;
  logic [10:0]       rcv_q, rcv_d, wr_q, wr_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [63:0]       td_q, td_d;
  logic              tsof_n_q, tsof_n_d, teof_n_q, teof_n_d, trem_n_q, trem_n_d;
  logic              tsrc_rdy_n_q, tsrc_rdy_n_d, cyc_n_q, cyc_n_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              mwe_q, mwe_d;
  logic [15:0]       stat_q, stat_d;
  logic [FQ_AW-1:0]  fq_wp_q, fq_wp_d, fq_rp_q, fq_rp_d;
  logic [FQ_AW:0]    fq_cnt_q, fq_cnt_d;
  logic [31:0]       fq_mem [2**FQ_AW];

  assign rst         = sys_rst | trn_lnk_up_n;
  assign req_id      = {cfg_bus_number, cfg_device_number, cfg_function_number};
  assign active      = (st_q == RQ_WAIT_CPL) || (st_q == RQ_CPL_DATA);
  assign unused_addr = ^req_addr[1:0];

  hm_rd_req_cpl_rx #(.TAG(TAG)) u_cpl_rx (
    .clk(trn_clk), .rst(rst), .active(active), .req_id(req_id),
    .trn_rd(trn_rd), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rrem_n(trn_rrem_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .dw_hi(rx_hi), .dw_lo(rx_lo), .vld_hi(rx_vhi), .vld_lo(rx_vlo),
    .last(rx_last), .err(rx_err)
  );

`ifdef HM_RD_REQ_TIMEOUT_EN
  logic [19:0] to_q, to_d;
  assign timeout = (to_q == TIMEOUT_CYC);
  assign to_d    = (!active || acc_hi || acc_lo) ? 20'd0 : to_q + 20'd1;
  always_ff @(posedge trn_clk) begin
    if (rst) to_q <= 20'd0;
    else     to_q <= to_d;
  end
`else
  logic unused_to;
  assign timeout   = 1'b0;
  assign unused_to = ^TIMEOUT_CYC;
`endif

  always_comb begin
    st_d = st_q;  addr_d = addr_q;  len_d = len_q;  busy_d = busy_q;
    done_d = 1'b0;  err_d = 1'b0;  stat_d = stat_q;
    td_d = td_q;  tsof_n_d = tsof_n_q;  teof_n_d = teof_n_q;  trem_n_d = trem_n_q;
    tsrc_rdy_n_d = tsrc_rdy_n_q;  cyc_n_d = cyc_n_q;
    mwe_d = 1'b0;  mdata_d = mdata_q;  maddr_d = maddr_q;
    start_bad = (req_len == 10'd0) || (req_len > MAX_LEN) ||
                (({1'b0, req_addr[11:2]} + {1'b0, req_len}) > 11'h400);

    // Surplus DWs beyond len are never accepted; hi precedes lo in stream order.
    acc_hi   = rx_vhi && active && (rcv_q < {1'b0, len_q});
    acc_lo   = rx_vlo && active && ((rcv_q + 11'(acc_hi)) < {1'b0, len_q});
    fq_empty = (fq_cnt_q == '0);
    pop_fq   = active && !fq_empty;
    push0    = 1'b0;
    push1    = 1'b0;
    push0_dw = acc_hi ? rx_hi : rx_lo;
    push1_dw = rx_lo;
    if (fq_empty) begin
      push0    = acc_hi && acc_lo;
      push0_dw = rx_lo;
    end else begin
      push0 = acc_hi || acc_lo;
      push1 = acc_hi && acc_lo;
    end
    wdw      = !fq_empty ? fq_mem[fq_rp_q] : (acc_hi ? rx_hi : rx_lo);
    wr_en    = pop_fq || acc_hi || acc_lo;
    rcv_d    = rcv_q + 11'(acc_hi) + 11'(acc_lo);
    wr_d     = wr_q + 11'(wr_en);
    fq_wp_d  = fq_wp_q + FQ_AW'(push0) + FQ_AW'(push1);
    fq_rp_d  = fq_rp_q + FQ_AW'(pop_fq);
    fq_cnt_d = fq_cnt_q + FQ_CW'(push0) + FQ_CW'(push1) - FQ_CW'(pop_fq);
    if (wr_en) begin
      mwe_d   = 1'b1;
      mdata_d = bswap32(wdw);
      maddr_d = MEM_AW'(wr_q);
    end

    case (st_q)
      RQ_IDLE: if (req_start) begin
        if (start_bad) err_d = 1'b1;
        else begin
          addr_d = req_addr[31:2];  len_d = req_len;  rcv_d = '0;  wr_d = '0;
          busy_d = 1'b1;  cyc_n_d = 1'b0;  tsof_n_d = 1'b0;  tsrc_rdy_n_d = 1'b0;
          trem_n_d = 1'b0;  td_d = mrd_qw0(req_len, req_id, TAG);
          st_d = RQ_HDR0;
        end
      end
      RQ_HDR0: if (!trn_tdst_rdy_n) begin
        td_d = {addr_q, 2'b00, 32'h0};
        tsof_n_d = 1'b1;  teof_n_d = 1'b0;  trem_n_d = 1'b1;
        st_d = RQ_HDR1;
      end
      RQ_HDR1: if (!trn_tdst_rdy_n) begin
        td_d = '0;  tsrc_rdy_n_d = 1'b1;  teof_n_d = 1'b1;  cyc_n_d = 1'b1;
        st_d = RQ_WAIT_CPL;
      end
      RQ_WAIT_CPL: if (acc_hi || acc_lo) st_d = rx_last ? RQ_WAIT_CPL : RQ_CPL_DATA;
      RQ_CPL_DATA: if (rx_last) st_d = RQ_WAIT_CPL;
      default:     st_d = RQ_IDLE;
    endcase

    if (active) begin
      if (wr_en && (wr_q + 11'd1 == {1'b0, len_q})) begin
        done_d = 1'b1;  busy_d = 1'b0;  stat_d = stat_q + 16'd1;  st_d = RQ_IDLE;
      end else if (rx_err || timeout) begin
        err_d = 1'b1;  busy_d = 1'b0;  st_d = RQ_IDLE;
      end
    end
    if (st_d == RQ_IDLE) begin
      fq_wp_d = '0;  fq_rp_d = '0;  fq_cnt_d = '0;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (rst) begin
      st_q <= RQ_IDLE;  addr_q <= '0;  len_q <= '0;  rcv_q <= '0;  wr_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;  stat_q <= '0;
      td_q <= '0;  tsof_n_q <= 1'b1;  teof_n_q <= 1'b1;  trem_n_q <= 1'b1;
      tsrc_rdy_n_q <= 1'b1;  cyc_n_q <= 1'b1;
      mwe_q <= 1'b0;  mdata_q <= '0;  maddr_q <= '0;
      fq_wp_q <= '0;  fq_rp_q <= '0;  fq_cnt_q <= '0;
    end else begin
      st_q <= st_d;  addr_q <= addr_d;  len_q <= len_d;  rcv_q <= rcv_d;  wr_q <= wr_d;
      busy_q <= busy_d;  done_q <= done_d;  err_q <= err_d;  stat_q <= stat_d;
      td_q <= td_d;  tsof_n_q <= tsof_n_d;  teof_n_q <= teof_n_d;  trem_n_q <= trem_n_d;
      tsrc_rdy_n_q <= tsrc_rdy_n_d;  cyc_n_q <= cyc_n_d;
      mwe_q <= mwe_d;  mdata_q <= mdata_d;  maddr_q <= maddr_d;
      fq_wp_q <= fq_wp_d;  fq_rp_q <= fq_rp_d;  fq_cnt_q <= fq_cnt_d;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (push0) fq_mem[fq_wp_q] <= push0_dw;
    if (push1) fq_mem[fq_wp_q + 1'b1] <= push1_dw;
  end

  assign req_busy       = busy_q;
  assign req_done       = done_q;
  assign req_err        = err_q;
  assign mem_addr       = maddr_q;
  assign mem_data       = mdata_q;
  assign mem_we         = mwe_q;
  assign trn_td         = td_q;
  assign trn_tsof_n     = tsof_n_q;
  assign trn_teof_n     = teof_n_q;
  assign trn_trem_n     = trem_n_q;
  assign trn_tsrc_rdy_n = tsrc_rdy_n_q;
  assign trn_cyc_n      = cyc_n_q;
  assign stat_rd_cnt    = stat_q;

endmodule

// File: tb/tb_hm_rd_req.sv
// Directed bench for hm_rd_req: request-acceptance table plus hand-built CplD sequences.
module tb_hm_rd_req;

  logic        trn_clk = 1'b0;
  logic        sys_rst = 1'b1, trn_lnk_up_n = 1'b0;
  logic        req_start = 1'b0;
  logic [31:0] req_addr = '0;
  logic [9:0]  req_len = '0;
  logic        req_busy, req_done, req_err, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [63:0] trn_td;
  logic        trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n, trn_cyc_n;
  logic        trn_tdst_rdy_n = 1'b0;
  logic [63:0] trn_rd = '0;
  logic        trn_rsof_n = 1'b1, trn_reof_n = 1'b1, trn_rrem_n = 1'b1, trn_rsrc_rdy_n = 1'b1;
  logic [15:0] stat_rd_cnt;

  hm_rd_req #(.TIMEOUT_CYC(20'd50)) dut (
    .trn_clk(trn_clk), .sys_rst(sys_rst), .trn_lnk_up_n(trn_lnk_up_n),
    .req_start(req_start), .req_addr(req_addr), .req_len(req_len),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .trn_td(trn_td), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n), .trn_trem_n(trn_trem_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_cyc_n(trn_cyc_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_rd(trn_rd), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rrem_n(trn_rrem_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .cfg_bus_number(8'h12), .cfg_device_number(5'h03), .cfg_function_number(3'h5),
    .stat_rd_cnt(stat_rd_cnt)
  );

  always #5 trn_clk = ~trn_clk;

  int n_cmp = 0, n_bad = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0, sof_cnt = 0;
  logic [31:0] mem_m [0:1023];

  always @(posedge trn_clk) begin
    if (mem_we) begin mem_m[mem_addr] = mem_data; we_cnt++; end
    if (req_done) done_cnt++;
    if (req_err) err_cnt++;
    if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n && !trn_tsof_n) sof_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk); #1;
  endtask

  task automatic clr_cnt();
    we_cnt = 0; done_cnt = 0; err_cnt = 0; sof_cnt = 0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
  endtask

  task automatic start_req(input logic [31:0] a, input logic [9:0] l);
    req_addr = a; req_len = l; req_start = 1'b1; tick(); req_start = 1'b0;
  endtask

  task automatic rx_beat(input logic [63:0] qw, input logic sof_n, input logic eof_n, input logic rem_n);
    trn_rd = qw; trn_rsof_n = sof_n; trn_reof_n = eof_n; trn_rrem_n = rem_n; trn_rsrc_rdy_n = 1'b0;
    tick();
    trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rrem_n = 1'b1;
  endtask

  // Idle RX cycles with junk on the bus that must be ignored.
  task automatic rx_stall(input int n);
    trn_rd = 64'hBAD0_BAD0_BAD0_BAD0; trn_reof_n = 1'b0; trn_rsrc_rdy_n = 1'b1;
    repeat (n) tick();
    trn_reof_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [9:0]  len;
    logic        err;
    logic [63:0] qw0;
    logic [63:0] qw1;
  } vec_t;
  vec_t vt [6];

  initial begin
    vt[0] = '{32'h0001_0008, 10'd1,   1'b0, 64'h00000001_121D010F, 64'h00010008_00000000};
    vt[1] = '{32'h0000_0000, 10'd0,   1'b1, 64'h0, 64'h0};
    vt[2] = '{32'h0000_0000, 10'd129, 1'b1, 64'h0, 64'h0};
    vt[3] = '{32'h0000_0FFC, 10'd2,   1'b1, 64'h0, 64'h0};
    vt[4] = '{32'h0000_0FF8, 10'd2,   1'b0, 64'h00000002_121D01FF, 64'h00000FF8_00000000};
    vt[5] = '{32'h8000_0003, 10'd128, 1'b0, 64'h00000080_121D01FF, 64'h80000000_00000000};

    tick(); tick();
    sys_rst = 1'b0; trn_lnk_up_n = 1'b1; tick();
    chk("lnkdown_busy", req_busy, 0);
    chk("lnkdown_tx", {trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n, trn_cyc_n}, 5'h1F);
    trn_lnk_up_n = 1'b0; tick();
    chk("rst_td", trn_td, 0);
    chk("rst_pulses", {req_done, req_err, mem_we}, 0);
    chk("rst_stat", stat_rd_cnt, 0);

    foreach (vt[i]) begin
      do_reset(); clr_cnt();
      start_req(vt[i].addr, vt[i].len);
      chk($sformatf("v%0d_err", i), req_err, vt[i].err);
      chk($sformatf("v%0d_busy", i), req_busy, !vt[i].err);
      if (!vt[i].err) begin
        chk($sformatf("v%0d_qw0", i), trn_td, vt[i].qw0);
        chk($sformatf("v%0d_qw0ctl", i), {trn_tsof_n, trn_tsrc_rdy_n, trn_cyc_n}, 3'b000);
        tick();
        chk($sformatf("v%0d_qw1", i), trn_td, vt[i].qw1);
        chk($sformatf("v%0d_qw1ctl", i), {trn_tsof_n, trn_teof_n, trn_trem_n}, 3'b101);
        tick();
        chk($sformatf("v%0d_rel", i), {trn_tsrc_rdy_n, trn_teof_n, trn_cyc_n}, 3'b111);
      end else begin
        chk($sformatf("v%0d_notx", i), {trn_tsrc_rdy_n, trn_cyc_n}, 2'b11);
        tick();
        chk($sformatf("v%0d_errpulse", i), req_err, 0);
      end
    end

    // len 1 round trip
    do_reset(); clr_cnt();
    start_req(32'h0001_0008, 10'd1); tick(); tick();
    rx_beat({32'h4A000001, 32'h00000004}, 1'b0, 1'b1, 1'b1);
    rx_beat({32'h121D0108, 32'h11223344}, 1'b1, 1'b0, 1'b0);
    chk("a_we", mem_we, 1);
    chk("a_data", mem_data, 32'h44332211);
    chk("a_addr", mem_addr, 0);
    chk("a_done", req_done, 1);
    tick();
    chk("a_idle", {req_busy, req_done}, 2'b00);
    chk("a_stat", stat_rd_cnt, 1);

    // len 4 as two 2-DW completions with source stalls
    clr_cnt();
    start_req(32'h0002_0000, 10'd4); tick(); tick();
    rx_beat({32'h4A000002, 32'h00000010}, 1'b0, 1'b1, 1'b1);
    rx_beat({32'h121D0100, 32'hA0A1A2A3}, 1'b1, 1'b1, 1'b1);
    rx_stall(2);
    rx_beat({32'hB0B1B2B3, 32'hDEADDEAD}, 1'b1, 1'b0, 1'b1);
    chk("b_busy_mid", req_busy, 1);
    rx_beat({32'h4A000002, 32'h00000008}, 1'b0, 1'b1, 1'b1);
    rx_beat({32'h121D0108, 32'hC0C1C2C3}, 1'b1, 1'b1, 1'b1);
    rx_stall(1);
    rx_beat({32'hD0D1D2D3, 32'hDEADDEAD}, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    chk("b_m0", mem_m[0], 32'hA3A2A1A0);
    chk("b_m1", mem_m[1], 32'hB3B2B1B0);
    chk("b_m2", mem_m[2], 32'hC3C2C1C0);
    chk("b_m3", mem_m[3], 32'hD3D2D1D0);
    chk("b_we", we_cnt, 4);
    chk("b_done", done_cnt, 1);
    chk("b_stat", stat_rd_cnt, 2);

    // len 3 from full QWs, two surplus DWs dropped
    clr_cnt();
    start_req(32'h0003_0000, 10'd3); tick(); tick();
    rx_beat({32'h4A000005, 32'h00000014}, 1'b0, 1'b1, 1'b1);
    rx_beat({32'h121D0100, 32'hE0E0E0E0}, 1'b1, 1'b1, 1'b1);
    rx_beat({32'hE1000001, 32'hE2000002}, 1'b1, 1'b1, 1'b1);
    rx_beat({32'hE3000003, 32'hE4000004}, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("c_m0", mem_m[0], 32'hE0E0E0E0);
    chk("c_m1", mem_m[1], 32'h010000E1);
    chk("c_m2", mem_m[2], 32'h020000E2);
    chk("c_m3_kept", mem_m[3], 32'hD3D2D1D0);
    chk("c_we", we_cnt, 3);
    chk("c_done", done_cnt, 1);
    chk("c_stat", stat_rd_cnt, 3);

    // destination not ready for 3 cycles in HDR0
    do_reset(); clr_cnt();
    trn_tdst_rdy_n = 1'b1;
    start_req(32'h0004_0000, 10'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("d_hold%0d", k), {trn_td, 7'(0), trn_tsof_n}, {64'h00000002_121D01FF, 8'h00});
    end
    trn_tdst_rdy_n = 1'b0; tick();
    chk("d_qw1", trn_td, 64'h00040000_00000000);
    tick(); tick();
    chk("d_sof_once", sof_cnt, 1);

    // wrong tag ignored, then bad status aborts
    do_reset(); clr_cnt();
    start_req(32'h0005_0000, 10'd1); tick(); tick();
    rx_beat({32'h4A000001, 32'h00000004}, 1'b0, 1'b1, 1'b1);
    rx_beat({32'h121D0208, 32'h99999999}, 1'b1, 1'b0, 1'b0);
    tick();
    chk("e_ignored", {req_busy, req_err}, 2'b10);
    rx_beat({32'h4A000001, 32'h00002004}, 1'b0, 1'b1, 1'b1);
    rx_beat({32'h121D0108, 32'h77777777}, 1'b1, 1'b0, 1'b0);
    chk("e_err", req_err, 1);
    tick();
    chk("e_busy", req_busy, 0);
    chk("e_nowrite", we_cnt, 0);
    chk("e_errcnt", err_cnt, 1);

    // sys_rst mid CPL_DATA
    do_reset(); clr_cnt();
    start_req(32'h0006_0000, 10'd4); tick(); tick();
    rx_beat({32'h4A000004, 32'h00000010}, 1'b0, 1'b1, 1'b1);
    rx_beat({32'h121D0100, 32'hF0F0F0F0}, 1'b1, 1'b1, 1'b1);
    sys_rst = 1'b1;
    rx_beat({32'hF1F1F1F1, 32'hF2F2F2F2}, 1'b1, 1'b1, 1'b1);
    sys_rst = 1'b0;
    chk("f_rst", {req_busy, mem_we, trn_cyc_n, trn_tsrc_rdy_n}, 4'b0011);
    chk("f_stat", stat_rd_cnt, 0);
    rx_beat({32'hF3F3F3F3, 32'h0}, 1'b1, 1'b0, 1'b1);
    tick();
    chk("f_we", we_cnt, 1);
    chk("f_done", done_cnt, 0);

`ifdef HM_RD_REQ_TIMEOUT_EN
    begin
      int wait_cyc;
      do_reset(); clr_cnt();
      start_req(32'h0007_0000, 10'd1); tick(); tick();
      wait_cyc = 0;
      while (!req_err && wait_cyc < 200) begin tick(); wait_cyc++; end
      chk("g_timeout_err", req_err, 1);
      chk("g_timeout_late", (wait_cyc >= 45), 1);
      tick();
      chk("g_busy", req_busy, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
